// File: rtl/alu_exec_if.sv
// Interface: alu_exec_if
// Bundles the execute-stage inputs (decoded control, operands, PC) and the
// registered EX/MEM outputs of alu_exec_unit.
//   master : drives en/in_valid/alu_op/funct/shamt/a/b/pc/imm_ext, observes results
//   slave  : the execute unit itself (consumes inputs, drives registered outputs)
interface alu_exec_if #(
    parameter int unsigned WIDTH = 32
);
    // Inputs to the execute stage
    logic             en;
    logic             in_valid;
    logic [1:0]       alu_op;
    logic [5:0]       funct;
    logic [4:0]       shamt;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] imm_ext;

    // Registered outputs (EX/MEM boundary)
    logic             out_valid;
    logic [3:0]       alu_ctrl;
    logic             jr;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             overflow;
    logic [WIDTH-1:0] pc_plus_4;
    logic [WIDTH-1:0] branch_target;

    modport master (
        output en, in_valid, alu_op, funct, shamt, a, b, pc, imm_ext,
        input  out_valid, alu_ctrl, jr, result, zero, overflow, pc_plus_4, branch_target
    );

    modport slave (
        input  en, in_valid, alu_op, funct, shamt, a, b, pc, imm_ext,
        output out_valid, alu_ctrl, jr, result, zero, overflow, pc_plus_4, branch_target
    );
endinterface

// File: rtl/alu_exec_unit.sv
// Module: alu_exec_unit
// Execute stage of the MIPS pipeline: ALU-control decode, 32-bit ALU and the
// PC+4 / branch-target adders. Every output is registered (1-cycle latency).
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset, clears all outputs
//   bus    : alu_exec_if.slave
//            in : en (0 = stall/hold), in_valid, alu_op, funct, shamt, a, b, pc, imm_ext
//            out: out_valid, alu_ctrl, jr, result, zero, overflow, pc_plus_4, branch_target
module alu_exec_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    alu_exec_if.slave  bus
);

    typedef enum logic [3:0] {
        AluAnd  = 4'b0000,
        AluOr   = 4'b0001,
        AluAdd  = 4'b0010,
        AluXor  = 4'b0011,
        AluSub  = 4'b0110,
        AluSlt  = 4'b0111,
        AluSll  = 4'b1000,
        AluSrl  = 4'b1001,
        AluSra  = 4'b1010,
        AluSltu = 4'b1011,
        AluNor  = 4'b1100
    } alu_ctrl_e;

    // ------------------------------------------------------------------
    // ALU control decode
    // ------------------------------------------------------------------
    alu_ctrl_e ctrl_d;
    logic      jr_d;
    logic      ovf_en; // only signed add/sub report overflow

    always_comb begin
        ctrl_d = AluAdd;
        jr_d   = 1'b0;
        ovf_en = 1'b0;
        unique case (bus.alu_op)
            2'b00: begin
                ctrl_d = AluAdd;
                ovf_en = 1'b1;
            end
            2'b01: begin
                ctrl_d = AluSub;
                ovf_en = 1'b1;
            end
            2'b11: ctrl_d = AluOr;
            2'b10: begin
                case (bus.funct)
                    6'h20: begin
                        ctrl_d = AluAdd;
                        ovf_en = 1'b1;
                    end
                    6'h21: ctrl_d = AluAdd;
                    6'h22: begin
                        ctrl_d = AluSub;
                        ovf_en = 1'b1;
                    end
                    6'h23: ctrl_d = AluSub;
                    6'h24: ctrl_d = AluAnd;
                    6'h25: ctrl_d = AluOr;
                    6'h26: ctrl_d = AluXor;
                    6'h27: ctrl_d = AluNor;
                    6'h2A: ctrl_d = AluSlt;
                    6'h2B: ctrl_d = AluSltu;
                    6'h00: ctrl_d = AluSll;
                    6'h02: ctrl_d = AluSrl;
                    6'h03: ctrl_d = AluSra;
                    6'h08: begin
                        ctrl_d = AluAdd;
                        jr_d   = 1'b1;
                    end
                    default: ctrl_d = AluAdd;
                endcase
            end
            default: ctrl_d = AluAdd;
        endcase
    end

    // ------------------------------------------------------------------
    // ALU datapath
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] result_d;
    logic             overflow_d;
    logic             sign_a;
    logic             sign_b;

    assign sum    = bus.a + bus.b;
    assign diff   = bus.a - bus.b;
    assign sign_a = bus.a[WIDTH-1];
    assign sign_b = bus.b[WIDTH-1];

    always_comb begin
        result_d = '0;
        unique case (ctrl_d)
            AluAnd:  result_d = bus.a & bus.b;
            AluOr:   result_d = bus.a | bus.b;
            AluAdd:  result_d = sum;
            AluXor:  result_d = bus.a ^ bus.b;
            AluSub:  result_d = diff;
            AluSlt:  result_d = {{(WIDTH-1){1'b0}}, $signed(bus.a) < $signed(bus.b)};
            AluSltu: result_d = {{(WIDTH-1){1'b0}}, bus.a < bus.b};
            // Shifts act on b by shamt; a is ignored.
            AluSll:  result_d = bus.b << bus.shamt;
            AluSrl:  result_d = bus.b >> bus.shamt;
            AluSra:  result_d = $unsigned($signed(bus.b) >>> bus.shamt);
            AluNor:  result_d = ~(bus.a | bus.b);
            default: result_d = '0;
        endcase
    end

    always_comb begin
        overflow_d = 1'b0;
        if (ovf_en) begin
            if (ctrl_d == AluAdd) begin
                overflow_d = (sign_a == sign_b) && (sum[WIDTH-1] != sign_a);
            end else if (ctrl_d == AluSub) begin
                overflow_d = (sign_a != sign_b) && (diff[WIDTH-1] != sign_a);
            end
        end
    end

    // ------------------------------------------------------------------
    // PC adders
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] pc_plus_4_d;
    logic [WIDTH-1:0] branch_target_d;

    assign pc_plus_4_d     = bus.pc + WIDTH'(4);
    // Word offset to byte offset; wraps modulo 2^WIDTH for negative offsets.
    assign branch_target_d = pc_plus_4_d + {bus.imm_ext[WIDTH-3:0], 2'b00};

    // ------------------------------------------------------------------
    // EX/MEM output registers
    // ------------------------------------------------------------------
    logic             out_valid_q;
    logic [3:0]       alu_ctrl_q;
    logic             jr_q;
    logic [WIDTH-1:0] result_q;
    logic             zero_q;
    logic             overflow_q;
    logic [WIDTH-1:0] pc_plus_4_q;
    logic [WIDTH-1:0] branch_target_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q     <= 1'b0;
            alu_ctrl_q      <= 4'b0000;
            jr_q            <= 1'b0;
            result_q        <= '0;
            zero_q          <= 1'b0;
            overflow_q      <= 1'b0;
            pc_plus_4_q     <= '0;
            branch_target_q <= '0;
        end else if (bus.en) begin
            out_valid_q     <= bus.in_valid;
            alu_ctrl_q      <= ctrl_d;
            jr_q            <= jr_d;
            result_q        <= result_d;
            zero_q          <= (result_d == '0);
            overflow_q      <= overflow_d;
            pc_plus_4_q     <= pc_plus_4_d;
            branch_target_q <= branch_target_d;
        end
    end

    assign bus.out_valid     = out_valid_q;
    assign bus.alu_ctrl      = alu_ctrl_q;
    assign bus.jr            = jr_q;
    assign bus.result        = result_q;
    assign bus.zero          = zero_q;
    assign bus.overflow      = overflow_q;
    assign bus.pc_plus_4     = pc_plus_4_q;
    assign bus.branch_target = branch_target_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Testbench: tb_alu_exec_unit
// Directed vectors with hand-computed expectations for alu_exec_unit.
module tb_alu_exec_unit;

    logic clk;
    logic rst_n;
    int   checks;
    int   passed;

    alu_exec_if #(.WIDTH(32)) bus ();

    alu_exec_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Advance one rising edge and settle past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] op, input logic [5:0] fn, input logic [4:0] sh,
                         input logic [31:0] av, input logic [31:0] bv);
        bus.alu_op = op;
        bus.funct  = fn;
        bus.shamt  = sh;
        bus.a      = av;
        bus.b      = bv;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".out_valid"}, {31'd0, bus.out_valid}, 32'd0);
        check({tag, ".alu_ctrl"}, {28'd0, bus.alu_ctrl}, 32'd0);
        check({tag, ".jr"}, {31'd0, bus.jr}, 32'd0);
        check({tag, ".result"}, bus.result, 32'd0);
        check({tag, ".zero"}, {31'd0, bus.zero}, 32'd0);
        check({tag, ".overflow"}, {31'd0, bus.overflow}, 32'd0);
        check({tag, ".pc_plus_4"}, bus.pc_plus_4, 32'd0);
        check({tag, ".branch_target"}, bus.branch_target, 32'd0);
    endtask

    initial begin
        checks = 0;
        passed = 0;
        rst_n        = 1'b0;
        bus.en       = 1'b1;
        bus.in_valid = 1'b1;
        bus.pc       = 32'h0000_0100;
        bus.imm_ext  = 32'hFFFF_FFFE;
        drive(2'b10, 6'h20, 5'd0, 32'd7, 32'd5);

        // Reset held: outputs zero even with en=1 across edges
        step();
        step();
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // add: 7+5
        step();
        check("add.result", bus.result, 32'd12);
        check("add.zero", {31'd0, bus.zero}, 32'd0);
        check("add.ctrl", {28'd0, bus.alu_ctrl}, 32'h2);
        check("add.ovf", {31'd0, bus.overflow}, 32'd0);
        check("add.valid", {31'd0, bus.out_valid}, 32'd1);
        check("pc_plus_4", bus.pc_plus_4, 32'h0000_0104);
        check("branch_neg", bus.branch_target, 32'h0000_00FC);

        // sub: 5-5 -> zero
        drive(2'b10, 6'h22, 5'd0, 32'd5, 32'd5);
        step();
        check("sub.result", bus.result, 32'd0);
        check("sub.zero", {31'd0, bus.zero}, 32'd1);
        check("sub.ctrl", {28'd0, bus.alu_ctrl}, 32'h6);

        // slt signed: -1 < 1
        drive(2'b10, 6'h2A, 5'd0, 32'hFFFF_FFFF, 32'd1);
        step();
        check("slt.result", bus.result, 32'd1);
        check("slt.ctrl", {28'd0, bus.alu_ctrl}, 32'h7);

        // sltu: 0xFFFFFFFF < 1 false
        drive(2'b10, 6'h2B, 5'd0, 32'hFFFF_FFFF, 32'd1);
        step();
        check("sltu.result", bus.result, 32'd0);
        check("sltu.ctrl", {28'd0, bus.alu_ctrl}, 32'hB);
        check("sltu.zero", {31'd0, bus.zero}, 32'd1);

        // sra / srl / sll
        drive(2'b10, 6'h03, 5'd4, 32'h1234_5678, 32'h8000_0000);
        step();
        check("sra.result", bus.result, 32'hF800_0000);
        check("sra.ctrl", {28'd0, bus.alu_ctrl}, 32'hA);
        drive(2'b10, 6'h02, 5'd4, 32'h1234_5678, 32'h8000_0000);
        step();
        check("srl.result", bus.result, 32'h0800_0000);
        check("srl.ctrl", {28'd0, bus.alu_ctrl}, 32'h9);
        drive(2'b10, 6'h00, 5'd31, 32'hFFFF_FFFF, 32'd1);
        step();
        check("sll.result", bus.result, 32'h8000_0000);
        check("sll.ctrl", {28'd0, bus.alu_ctrl}, 32'h8);

        // jr
        drive(2'b10, 6'h08, 5'd0, 32'h0000_0010, 32'd0);
        step();
        check("jr.flag", {31'd0, bus.jr}, 32'd1);
        check("jr.ctrl", {28'd0, bus.alu_ctrl}, 32'h2);
        check("jr.result", bus.result, 32'h0000_0010);

        // add overflow vs addu
        drive(2'b10, 6'h20, 5'd0, 32'h7FFF_FFFF, 32'd1);
        step();
        check("addovf.result", bus.result, 32'h8000_0000);
        check("addovf.ovf", {31'd0, bus.overflow}, 32'd1);
        check("addovf.jr", {31'd0, bus.jr}, 32'd0);
        drive(2'b10, 6'h21, 5'd0, 32'h7FFF_FFFF, 32'd1);
        step();
        check("addu.result", bus.result, 32'h8000_0000);
        check("addu.ovf", {31'd0, bus.overflow}, 32'd0);

        // alu_op=01 sub overflow: 0x80000000 - 1
        drive(2'b01, 6'h3F, 5'd0, 32'h8000_0000, 32'd1);
        step();
        check("op01.result", bus.result, 32'h7FFF_FFFF);
        check("op01.ovf", {31'd0, bus.overflow}, 32'd1);
        check("op01.ctrl", {28'd0, bus.alu_ctrl}, 32'h6);

        // alu_op=11 OR
        drive(2'b11, 6'h20, 5'd0, 32'h0000_00F0, 32'h0000_000F);
        step();
        check("op11.result", bus.result, 32'h0000_00FF);
        check("op11.ctrl", {28'd0, bus.alu_ctrl}, 32'h1);

        // and / xor / nor
        drive(2'b10, 6'h24, 5'd0, 32'h0000_F0F0, 32'h0000_FF00);
        step();
        check("and.result", bus.result, 32'h0000_F000);
        drive(2'b10, 6'h26, 5'd0, 32'h0000_F0F0, 32'h0000_FF00);
        step();
        check("xor.result", bus.result, 32'h0000_0FF0);
        check("xor.ctrl", {28'd0, bus.alu_ctrl}, 32'h3);
        drive(2'b10, 6'h27, 5'd0, 32'd0, 32'd0);
        step();
        check("nor.result", bus.result, 32'hFFFF_FFFF);
        check("nor.ctrl", {28'd0, bus.alu_ctrl}, 32'hC);

        // Unlisted funct -> ADD, jr=0; in_valid=0 still updates; PC wrap
        drive(2'b10, 6'h3F, 5'd0, 32'd3, 32'd4);
        bus.in_valid = 1'b0;
        bus.pc       = 32'hFFFF_FFFC;
        bus.imm_ext  = 32'd1;
        step();
        check("unl.result", bus.result, 32'd7);
        check("unl.ctrl", {28'd0, bus.alu_ctrl}, 32'h2);
        check("unl.jr", {31'd0, bus.jr}, 32'd0);
        check("unl.valid", {31'd0, bus.out_valid}, 32'd0);
        check("pc_wrap", bus.pc_plus_4, 32'd0);
        check("branch_wrap", bus.branch_target, 32'd4);

        // Stall: en=0 holds everything
        bus.en       = 1'b0;
        bus.in_valid = 1'b1;
        bus.pc       = 32'h0000_0100;
        drive(2'b10, 6'h08, 5'd0, 32'd100, 32'd200);
        step();
        step();
        check("hold.result", bus.result, 32'd7);
        check("hold.jr", {31'd0, bus.jr}, 32'd0);
        check("hold.valid", {31'd0, bus.out_valid}, 32'd0);
        check("hold.pc_plus_4", bus.pc_plus_4, 32'd0);

        // Mid-run asynchronous reset: clears immediately, no edge needed
        bus.en = 1'b1;
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        step();
        check_all_zero("rst_held");
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("post_rst.result", bus.result, 32'd300);
        check("post_rst.jr", {31'd0, bus.jr}, 32'd1);
        check("post_rst.pc_plus_4", bus.pc_plus_4, 32'h0000_0104);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
